// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU issue controller.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_E = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } issueStateT;

  // Opcodes 3 and 7 are the only encodings with both low bits set.
  function automatic logic is_legal_op(input logic [2:0] op);
    return !(op[1] && op[0]);
  endfunction

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signal bundle between a requester and alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int COUNT_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_a;
  logic [3:0]         req_b;
  logic [2:0]         req_op;
  logic               req_cin;
  logic               req_chain;
  logic [3:0]         alu_a;
  logic [3:0]         alu_b;
  logic [2:0]         alu_op;
  logic               alu_cin;
  logic [7:0]         alu_y;
  logic               alu_cout;
  logic               alu_ovf;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [7:0]         rsp_y;
  logic [3:0]         rsp_flags;
  logic               carry_q;
  logic               busy;
  logic [COUNT_W-1:0] op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_cin, req_chain,
    input  alu_y, alu_cout, alu_ovf, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, alu_cin,
    output rsp_valid, rsp_y, rsp_flags, carry_q, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_cin, req_chain,
    output alu_y, alu_cout, alu_ovf, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, alu_cin,
    input  rsp_valid, rsp_y, rsp_flags, carry_q, busy, op_count
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Masks the raw ALU result per opcode and derives {E,V,C,Z} plus the carry-update enable.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [2:0] aluOp,
  input  logic [7:0] aluY,
  input  logic       aluCout,
  input  logic       aluOvf,
  output logic [7:0] resY,
  output logic [3:0] resFlags,
  output logic       carryEn
);

  always_comb begin
    resY     = '0;
    resFlags = '0;
    carryEn  = 1'b0;
    if (!is_legal_op(aluOp)) begin
      resFlags[FLG_E] = 1'b1;
    end else if (aluOp == OP_MUL) begin
      resY = aluY;
    end else begin
      resY = {4'b0000, aluY[3:0]};
    end
    if (is_arith_op(aluOp)) begin
      resFlags[FLG_C] = aluCout;
      resFlags[FLG_V] = aluOvf;
      carryEn         = 1'b1;
    end
    resFlags[FLG_Z] = (resY == 8'd0);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registers requests onto the combinational ALU, waits SETTLE_CYCLES, then holds the
// captured result on a valid/ready response port while tracking a chainable carry.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus
);

  if (SETTLE_CYCLES < 1) begin : gBadSettle
    $error("alu_issue_ctrl: SETTLE_CYCLES must be >= 1");
  end

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  issueStateT         stateQ, stateD;
  logic [CNT_W-1:0]   settleCntQ;
  logic [3:0]         aluAQ, aluBQ;
  logic [2:0]         aluOpQ;
  logic               aluCinQ;
  logic [7:0]         rspYQ;
  logic [3:0]         rspFlagsQ;
  logic               carryQ;
  logic [COUNT_W-1:0] opCountQ;

  logic               accept, capture, rspDone;
  logic [7:0]         resY;
  logic [3:0]         resFlags;
  logic               carryEn;

  assign accept  = (stateQ == IDLE)   && bus.req_valid;
  assign capture = (stateQ == SETTLE) && (settleCntQ == CNT_ONE);
  assign rspDone = (stateQ == RESP)   && bus.rsp_ready;

  alu_flag_gen uFlagGen (
    .aluOp    (aluOpQ),
    .aluY     (bus.alu_y),
    .aluCout  (bus.alu_cout),
    .aluOvf   (bus.alu_ovf),
    .resY     (resY),
    .resFlags (resFlags),
    .carryEn  (carryEn)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (accept)  stateD = SETTLE;
      SETTLE:  if (capture) stateD = RESP;
      RESP:    if (rspDone) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Operands stay on the ALU after a response so its inputs only move on a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCntQ <= '0;
      aluAQ      <= '0;
      aluBQ      <= '0;
      aluOpQ     <= '0;
      aluCinQ    <= 1'b0;
      rspYQ      <= '0;
      rspFlagsQ  <= '0;
      carryQ     <= 1'b0;
      opCountQ   <= '0;
    end else begin
      if (accept) begin
        aluAQ      <= bus.req_a;
        aluBQ      <= bus.req_b;
        aluOpQ     <= bus.req_op;
        aluCinQ    <= bus.req_chain ? carryQ : bus.req_cin;
        settleCntQ <= CNT_LOAD;
      end else if (stateQ == SETTLE) begin
        settleCntQ <= settleCntQ - CNT_ONE;
      end
      if (capture) begin
        rspYQ     <= resY;
        rspFlagsQ <= resFlags;
        if (carryEn) carryQ <= bus.alu_cout;
      end
      if (rspDone) opCountQ <= opCountQ + COUNT_W'(1);
    end
  end

  assign bus.req_ready = (stateQ == IDLE);
  assign bus.busy      = (stateQ != IDLE);
  assign bus.rsp_valid = (stateQ == RESP);
  assign bus.alu_a     = aluAQ;
  assign bus.alu_b     = aluBQ;
  assign bus.alu_op    = aluOpQ;
  assign bus.alu_cin   = aluCinQ;
  assign bus.rsp_y     = rspYQ;
  assign bus.rsp_flags = rspFlagsQ;
  assign bus.carry_q   = carryQ;
  assign bus.op_count  = opCountQ;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench: two controllers (SETTLE 1 / COUNT_W 8 and SETTLE 3 / COUNT_W 3) each wired to an
// ALU model, driven with directed and random traffic and compared to a transaction model.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstN = 2'b00;
  logic [1:0] reqValid, reqCin, reqChain, rspReady;
  logic [3:0] reqA [2];
  logic [3:0] reqB [2];
  logic [2:0] reqOp [2];

  wire  [1:0] reqReadyW, rspValidW, busyW, carryW, aluCinW;
  wire  [7:0] rspYW [2];
  wire  [3:0] flagsW [2];
  wire  [3:0] aluAW [2];
  wire  [3:0] aluBW [2];
  wire  [2:0] aluOpW [2];
  wire  [7:0] opCountW [2];

  int nChecks = 0;
  int nErrors = 0;

  // Team ALU: ADD/SUB report the 5-bit result in Y, illegal opcodes emit garbage.
  function automatic logic [9:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic cin);
    logic [4:0] s;
    logic [7:0] y;
    logic co, ov;
    y = 8'h00; co = 1'b0; ov = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        y = {3'b0, s}; co = s[4]; ov = (a[3] == b[3]) && (s[3] != a[3]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        y = {3'b0, s}; co = s[4]; ov = (a[3] != b[3]) && (s[3] != a[3]);
      end
      3'd2: y = {4'b0, a} * {4'b0, b};
      3'd4: y = {4'b0, a & b};
      3'd5: y = {4'b0, a | b};
      3'd6: y = {4'b0, a ^ b};
      default: begin y = 8'hFF; co = 1'b1; ov = 1'b1; end
    endcase
    return {y, co, ov};
  endfunction

  // Expected {rsp_y, {E,V,C,Z}, new carry} for one operation.
  function automatic logic [12:0] expRsp(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op, input logic cin,
                                         input logic prevCarry);
    logic [9:0] al;
    logic legal, arith;
    logic [7:0] y;
    al    = aluRef(a, b, op, cin);
    legal = !(op == 3'd3 || op == 3'd7);
    arith = (op == 3'd0) || (op == 3'd1);
    if (!legal)          y = 8'h00;
    else if (op == 3'd2) y = al[9:2];
    else                 y = {4'b0, al[5:2]};
    return {y, !legal, arith & al[0], arith & al[1], (y == 8'h00), arith ? al[1] : prevCarry};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S  = (g == 0) ? 1 : 3;
    localparam int CW = (g == 0) ? 8 : 3;
    alu_issue_ctrl_if #(.COUNT_W(CW)) ifc ();
    alu_issue_ctrl #(.SETTLE_CYCLES(S), .COUNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rstN[g]),
      .bus   (ifc)
    );
    logic [9:0] aluOut;
    assign aluOut        = aluRef(ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.alu_cin);
    assign ifc.alu_y     = aluOut[9:2];
    assign ifc.alu_cout  = aluOut[1];
    assign ifc.alu_ovf   = aluOut[0];
    assign ifc.req_valid = reqValid[g];
    assign ifc.req_a     = reqA[g];
    assign ifc.req_b     = reqB[g];
    assign ifc.req_op    = reqOp[g];
    assign ifc.req_cin   = reqCin[g];
    assign ifc.req_chain = reqChain[g];
    assign ifc.rsp_ready = rspReady[g];
    assign reqReadyW[g]  = ifc.req_ready;
    assign rspValidW[g]  = ifc.rsp_valid;
    assign busyW[g]      = ifc.busy;
    assign carryW[g]     = ifc.carry_q;
    assign aluCinW[g]    = ifc.alu_cin;
    assign rspYW[g]      = ifc.rsp_y;
    assign flagsW[g]     = ifc.rsp_flags;
    assign aluAW[g]      = ifc.alu_a;
    assign aluBW[g]      = ifc.alu_b;
    assign aluOpW[g]     = ifc.alu_op;
    assign opCountW[g]   = 8'(ifc.op_count);
  end

  function automatic int settleOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int countMask(input int i);
    return (i == 0) ? 255 : 7;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state per instance
  bit         mBusy [2];
  bit         mValid [2];
  int         mLeft [2];
  int         mCount [2];
  logic [3:0] mA [2];
  logic [3:0] mB [2];
  logic [2:0] mOp [2];
  logic       mCin [2];
  logic       mCarry [2];
  logic [7:0] mY [2];
  logic [3:0] mF [2];

  task automatic checkInst(input int i);
    logic [12:0] r;
    string p;
    p = $sformatf("i%0d ", i);
    if (!rstN[i]) begin
      chk({p, "rst rsp_valid"}, rspValidW[i], 0);
      chk({p, "rst busy"}, busyW[i], 0);
      chk({p, "rst rsp_y"}, rspYW[i], 0);
      chk({p, "rst flags"}, flagsW[i], 0);
      chk({p, "rst carry"}, carryW[i], 0);
      chk({p, "rst op_count"}, opCountW[i], 0);
      chk({p, "rst alu"}, {aluAW[i], aluBW[i], aluOpW[i], aluCinW[i]}, 0);
      mBusy[i] = 0; mValid[i] = 0; mLeft[i] = 0; mCount[i] = 0;
      mA[i] = 0; mB[i] = 0; mOp[i] = 0; mCin[i] = 0; mCarry[i] = 0;
      mY[i] = 0; mF[i] = 0;
    end else begin
      chk({p, "req_ready"}, reqReadyW[i], !mBusy[i]);
      chk({p, "busy"}, busyW[i], mBusy[i]);
      chk({p, "rsp_valid"}, rspValidW[i], mValid[i]);
      chk({p, "rsp_y"}, rspYW[i], mY[i]);
      chk({p, "rsp_flags"}, flagsW[i], mF[i]);
      chk({p, "carry_q"}, carryW[i], mCarry[i]);
      chk({p, "op_count"}, opCountW[i], mCount[i] & countMask(i));
      chk({p, "alu inputs"}, {aluAW[i], aluBW[i], aluOpW[i], aluCinW[i]},
          {mA[i], mB[i], mOp[i], mCin[i]});
      if (!mBusy[i]) begin
        if (reqValid[i]) begin
          mA[i] = reqA[i]; mB[i] = reqB[i]; mOp[i] = reqOp[i];
          mCin[i] = reqChain[i] ? mCarry[i] : reqCin[i];
          mBusy[i] = 1; mLeft[i] = settleOf(i);
        end
      end else if (!mValid[i]) begin
        mLeft[i]--;
        if (mLeft[i] == 0) begin
          r = expRsp(mA[i], mB[i], mOp[i], mCin[i], mCarry[i]);
          mY[i] = r[12:5]; mF[i] = r[4:1]; mCarry[i] = r[0];
          mValid[i] = 1;
        end
      end else if (rspReady[i]) begin
        mValid[i] = 0; mBusy[i] = 0; mCount[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) checkInst(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendReq(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic cin, input logic chain);
    int got;
    reqA[i] = a; reqB[i] = b; reqOp[i] = op; reqCin[i] = cin; reqChain[i] = chain;
    reqValid[i] = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reqReadyW[i]) begin got = 1; break; end
    end
    chk($sformatf("i%0d accept", i), got, 1);
    tick();
    reqValid[i] = 1'b0;
  endtask

  task automatic waitRsp(input int i);
    int lat;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rspValidW[i]) begin lat = n; break; end
    end
    chk($sformatf("i%0d latency", i), lat, settleOf(i));
  endtask

  task automatic ackRsp(input int i);
    rspReady[i] = 1'b1;
    tick();
    rspReady[i] = 1'b0;
  endtask

  task automatic checkRsp(input int i, input string name, input logic [7:0] y,
                          input logic [3:0] f, input logic c);
    chk($sformatf("i%0d %s y", i, name), rspYW[i], y);
    chk($sformatf("i%0d %s flags", i, name), flagsW[i], f);
    chk($sformatf("i%0d %s carry", i, name), carryW[i], c);
  endtask

  task automatic runInst(input int i);
    int hs, done;
    rstN[i] = 1'b0;
    tick(); tick();
    rstN[i] = 1'b1;
    chk($sformatf("i%0d post-reset req_ready", i), reqReadyW[i], 1);
    chk($sformatf("i%0d post-reset busy", i), busyW[i], 0);

    sendReq(i, 4'd9, 4'd8, 3'd0, 1'b0, 1'b0); waitRsp(i);
    checkRsp(i, "add 9+8", 8'h01, 4'b0110, 1'b1); ackRsp(i);
    sendReq(i, 4'd2, 4'd3, 3'd0, 1'b0, 1'b1);
    chk($sformatf("i%0d chain alu_cin", i), aluCinW[i], 1);
    waitRsp(i); checkRsp(i, "chain add", 8'h06, 4'b0000, 1'b0); ackRsp(i);
    sendReq(i, 4'hF, 4'h1, 3'd0, 1'b0, 1'b0); waitRsp(i);
    checkRsp(i, "add F+1", 8'h00, 4'b0011, 1'b1); ackRsp(i);
    sendReq(i, 4'hF, 4'hF, 3'd2, 1'b0, 1'b0); waitRsp(i);
    checkRsp(i, "mult", 8'hE1, 4'b0000, 1'b1); ackRsp(i);
    sendReq(i, 4'hA, 4'h5, 3'd4, 1'b0, 1'b0); waitRsp(i);
    checkRsp(i, "and", 8'h00, 4'b0001, 1'b1); ackRsp(i);
    sendReq(i, 4'd3, 4'd3, 3'd7, 1'b0, 1'b0); waitRsp(i);
    checkRsp(i, "illegal", 8'h00, 4'b1001, 1'b1);
    chk($sformatf("i%0d count before ack", i), opCountW[i], 5);
    ackRsp(i);
    chk($sformatf("i%0d count after ack", i), opCountW[i], 6);

    // Backpressure with the next request already pending
    sendReq(i, 4'd5, 4'd3, 3'd1, 1'b0, 1'b0); waitRsp(i);
    reqA[i] = 4'd6; reqB[i] = 4'd3; reqOp[i] = 3'd6; reqChain[i] = 1'b0;
    reqValid[i] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("i%0d bp req_ready", i), reqReadyW[i], 0);
      checkRsp(i, "bp sub", 8'h02, 4'b0000, 1'b0);
    end
    ackRsp(i);
    chk($sformatf("i%0d reenter idle", i), reqReadyW[i], 1);
    tick();
    chk($sformatf("i%0d next accepted", i), busyW[i], 1);
    reqValid[i] = 1'b0;
    waitRsp(i); checkRsp(i, "xor", 8'h05, 4'b0000, 1'b0); ackRsp(i);

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      sendReq(i, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom));
      done = 0;
      for (int k = 0; k < 60; k++) begin
        rspReady[i] = 1'($urandom);
        @(negedge clk);
        hs = int'(rspValidW[i] && rspReady[i]);
        tick();
        if (hs != 0) begin done = 1; break; end
      end
      rspReady[i] = 1'b0;
      chk($sformatf("i%0d random handshake", i), done, 1);
    end

    // Reset while the operation is still settling
    sendReq(i, 4'd7, 4'd7, 3'd0, 1'b1, 1'b0);
    rstN[i] = 1'b0;
    #1;
    chk($sformatf("i%0d abort rsp_valid", i), rspValidW[i], 0);
    chk($sformatf("i%0d abort busy", i), busyW[i], 0);
    chk($sformatf("i%0d abort alu", i), {aluAW[i], aluBW[i], aluOpW[i], aluCinW[i]}, 0);
    chk($sformatf("i%0d abort outputs", i), {rspYW[i], flagsW[i], carryW[i]}, 0);
    chk($sformatf("i%0d abort op_count", i), opCountW[i], 0);
    tick(); tick();
    rstN[i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("i%0d no stale rsp", i), rspValidW[i], 0);
    end
    chk($sformatf("i%0d final op_count", i), opCountW[i], 0);
  endtask

  initial begin
    reqValid = '0; reqCin = '0; reqChain = '0; rspReady = '0;
    for (int i = 0; i < 2; i++) begin
      reqA[i] = '0; reqB[i] = '0; reqOp[i] = '0;
    end
    tick();
    runInst(0);
    runInst(1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", nChecks, nErrors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front/back end for the team's combinational 4-bit ALU (3-bit opcode, 8-bit Y, CarryOUT, overflow). Accepts operation requests on a valid/ready handshake and registers the operands onto the ALU inputs. After a fixed settle time it captures the ALU result and flags. It presents them on a valid/ready response port and keeps a persistent carry flag so multi-nibble add/sub chains can be built.

Parameters:
SETTLE_CYCLES, 1, cycles the ALU inputs are held before result capture; must be >=1 (elaboration error otherwise)
COUNT_W, 8, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request ready
req_a  in  4  operand A
req_b  in  4  operand B
req_op  in  3  opcode: 0 ADD, 1 SUB, 2 MULT, 4 AND, 5 OR, 6 XOR; 3 and 7 are illegal
req_cin  in  1  explicit carry-in
req_chain  in  1  1: use stored carry_q as carry-in instead of req_cin
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_op  out  3  registered opcode to ALU
alu_cin  out  1  registered carry-in to ALU
alu_y  in  8  ALU result
alu_cout  in  1  ALU CarryOUT
alu_ovf  in  1  ALU overflow
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_y  out  8  captured result
rsp_flags  out  4  {E,V,C,Z}: illegal-op, overflow, carry, zero
carry_q  out  1  stored carry flag
busy  out  1  state != IDLE
op_count  out  COUNT_W  completed response handshakes, wraps modulo 2^COUNT_W

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all alu_* = 0, rsp_y=0, rsp_flags=0, rsp_valid=0, carry_q=0, op_count=0, settle counter=0. busy=0 and req_ready=1 once reset is released.
- Any in-flight operation is discarded on reset. No response is produced for it.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On the edge where req_valid&&req_ready: load alu_a=req_a, alu_b=req_b, alu_op=req_op, alu_cin = req_chain ? carry_q : req_cin. carry_q is sampled as it is at that edge.
  - Load the settle counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - req_ready=0; alu_* held constant.
  - The counter decrements each edge. On the edge where the counter equals 1, capture the result, set rsp_valid=1 and go to RESP.
  - Result: if accepted at edge k, rsp_valid rises after edge k+SETTLE_CYCLES.
- Capture rules:
  - MULT: rsp_y=alu_y.
  - ADD/SUB/AND/OR/XOR: rsp_y={4'b0, alu_y[3:0]}.
  - Illegal op (3,7): rsp_y=0, E=1.
  - C=alu_cout and V=alu_ovf for ADD/SUB only; otherwise C=V=0.
  - Z = (rsp_y==0), including for illegal ops.
  - carry_q <= alu_cout only on ADD/SUB capture; otherwise unchanged.
- RESP:
  - rsp_valid=1; rsp_y and rsp_flags stable until the handshake.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, op_count<=op_count+1 (wraps), go to IDLE.
  - rsp_y and rsp_flags keep their last values after the handshake.
- Minimum request-to-request period: SETTLE_CYCLES+2 cycles with rsp_ready tied high.
- req_valid while not IDLE is ignored; the requester must hold it. rsp_ready outside RESP has no effect.
- alu_* keep their last values in IDLE, so ALU inputs do not toggle between operations.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=4, OP_OR=5, OP_XOR=6
  - function is_legal_op, function is_arith_op
  - flag bit indices FLG_Z=0, FLG_C=1, FLG_V=2, FLG_E=3
  - state encoding IDLE/SETTLE/RESP
- One sub-module, alu_flag_gen (combinational): from alu_op, alu_y, alu_cout and alu_ovf it produces the masked result, the 4 flags and the carry-update enable. The FSM, counter and registers live in alu_issue_ctrl.

Test Plan:
- Reset then ADD: A=9, B=8, cin=0, SETTLE_CYCLES=1, bench connects the team's 4-bit ALU -> rsp_valid exactly 1 cycle after accept; rsp_y=0x01, flags E0 V1 C1 Z0; carry_q=1.
- Chained ADD after the previous case: A=2, B=3, req_chain=1, req_cin=0 -> alu_cin=1, rsp_y=0x06, C=0, carry_q=0.
- MULT A=15, B=15 -> rsp_y=0xE1, C=V=Z=E=0, carry_q unchanged. AND A=0xA, B=0x5 -> rsp_y=0x00, Z=1.
- Illegal op 7 with A=3, B=3 -> rsp_y=0, flags E1 Z1 C0 V0, carry_q unchanged, op_count increments on handshake.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid held high -> req_ready stays 0, rsp_y and rsp_flags stable. After rsp_ready=1, IDLE is re-entered and the next request is accepted 1 cycle later. Repeat with SETTLE_CYCLES=3 to check the 3-cycle latency.
- Assert rst_n=0 mid-SETTLE -> all outputs return to their reset values immediately; no rsp_valid ever appears for the aborted op; op_count=0.
